mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port memory bus between instruction fetch (IF) and load/store (DM).
//  One outstanding transaction; req/gnt address phase, rvalid data phase.
//  Applies DM-over-IF priority and drops fetch responses killed by a branch flush.
//  Sits between the IF/MEM stages and the unified memory.
// PARAMETERS
//  ADDR_W      32  byte-address width
//  DATA_W      32  data width; byte-enable width = DATA_W/8
//  STARVE_MAX  4   consecutive DM grants allowed while if_req is pending (guard build only)
// PORTS
//  clk        in   1         clock, rising edge
//  reset      in   1         asynchronous, active-low
//  cpu_en     in   1         0: no new grants; an in-flight transaction still completes
//  if_req     in   1         fetch request; held with if_addr until if_gnt
//  if_addr    in   ADDR_W    fetch address
//  if_flush   in   1         branch taken: kill the outstanding fetch response
//  if_gnt     out  1         fetch address accepted
//  if_rvalid  out  1         fetch data valid, one cycle
//  if_rdata   out  DATA_W    fetch data
//  dm_req     in   1         data request; held with its fields until dm_gnt
//  dm_we      in   1         1 = write
//  dm_addr    in   ADDR_W    data address
//  dm_wdata   in   DATA_W    write data
//  dm_be      in   DATA_W/8  byte enables
//  dm_gnt     out  1         data address accepted
//  dm_rvalid  out  1         read data valid / write ack, one cycle
//  dm_rdata   out  DATA_W    read data
//  mem_req/mem_we/mem_addr/mem_wdata/mem_be  out  1/1/ADDR_W/DATA_W/DATA_W/8  memory address phase
//  mem_gnt    in   1         memory accepts the address phase
//  mem_rvalid in   1         memory response (reads and writes), >=1 cycle after mem_gnt
//  mem_rdata  in   DATA_W    memory read data
// BEHAVIOUR
//  - States: IDLE, REQ_IF, REQ_DM, RSP_IF, RSP_DM. Reset (async) -> IDLE, drop flag 0, counter 0.
//  - While reset=0 every output is 0; pending transactions are lost.
//  - IDLE, cpu_en=1: dm_req wins, else if_req. The winner drives mem_* combinationally in
//    the same cycle. mem_gnt=1 -> RSP_x; else -> REQ_x. No request or cpu_en=0: stay, mem_req=0.
//  - REQ_x: owner locked; mem_* track that owner only, even if the other requester asserts.
//    mem_gnt -> RSP_x.
//  - Grant: x_gnt = mem_gnt while x owns the address phase (0-cycle pass-through).
//  - Non-owner mem_* fields: mem_we=0; address, data and byte enables are don't-care.
//  - RSP_x: mem_req=0. On mem_rvalid, pulse x_rvalid for one cycle; x_rdata=mem_rdata in that
//    cycle, otherwise 0; next state IDLE. Best throughput: one transaction per 2 cycles.
//  - Flush: if_flush=1 in REQ_IF or RSP_IF, or in the IF grant cycle, sets the drop flag.
//    The fetch still completes on the bus; its if_rvalid is suppressed.
//    Flush in the same cycle as mem_rvalid also suppresses it. The flag clears on leaving RSP_IF.
//  - if_flush in IDLE, REQ_DM or RSP_DM: no effect.
//  - Simultaneous if_req and dm_req in IDLE: DM granted. IF is served at the next IDLE.
//  - cpu_en falling mid-transaction: no effect until IDLE.
// CONFIGURATION
//  `ARB_IF_STARVE_GUARD_EN defined:
//   - 3-bit saturating counter increments on each DM grant with if_req=1.
//   - It clears on an IF grant or when if_req=0 in IDLE.
//   - At counter=STARVE_MAX, the next IDLE arbitration picks IF even if dm_req=1.
//  Undefined: strict DM priority; no counter logic.
// TESTING
//  1 Read fetch: if_req, addr 0x100, mem_gnt same cycle, rvalid 2 cycles later, rdata 0x00000013
//    -> if_gnt cycle 0, if_rvalid with 0x13 cycle 2.
//  2 Contention: if_req and dm_req (read 0x2000) in IDLE -> dm_gnt first, dm_rvalid.
//    Then if_gnt at the next IDLE; mem_addr never switches while mem_gnt=0.
//  3 Wait states: mem_gnt held 0 for 3 cycles -> REQ_IF holds mem_addr=if_addr.
//    dm_req raised meanwhile is not granted.
//  4 Flush: if_flush in RSP_IF, mem_rvalid with 0xDEADBEEF 2 cycles later -> if_rvalid stays 0.
//    Arbiter returns to IDLE. Repeat with flush coincident with mem_rvalid -> also suppressed.
//  5 Reset mid-transaction: reset=0 in RSP_DM -> all outputs 0 at once.
//    A later mem_rvalid produces no dm_rvalid.
//  6 Guard build, STARVE_MAX=4: dm_req always 1, if_req 1 -> 4 DM grants, then IF grant.
//    Without the macro: IF never granted.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-outstanding memory bus between fetch (IF) and load/store (DM).
// Optional IF starvation guard enabled by defining ARB_IF_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_en,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);
    typedef enum logic [2:0] {IDLE, REQ_IF, REQ_DM, RSP_IF, RSP_DM} state_e;
    state_e state_q, state_d;
    logic   drop_q, drop_d;
    logic   idle, starved, pick_if, pick_dm, own_if, own_dm, rsp_done;
`ifdef ARB_IF_STARVE_GUARD_EN
    logic [2:0] cnt_q, cnt_d;
    assign starved = cnt_q >= 3'(STARVE_MAX);
    always_comb begin
        cnt_d = cnt_q;
        if (if_gnt || (idle && !if_req))
            cnt_d = 3'd0;
        else if (dm_gnt && if_req && cnt_q != 3'd7)
            cnt_d = cnt_q + 3'd1;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt_q <= 3'd0;
        else        cnt_q <= cnt_d;
`else
    assign starved = 1'b0;
`endif
    // Reset gates arbitration so every output reads 0 while reset is held.
    assign idle    = state_q == IDLE;
    assign pick_dm = reset && idle && cpu_en && dm_req && !(starved && if_req);
    assign pick_if = reset && idle && cpu_en && if_req && !pick_dm;
    assign own_if  = pick_if || state_q == REQ_IF;
    assign own_dm  = pick_dm || state_q == REQ_DM;
    assign rsp_done = (state_q == RSP_IF || state_q == RSP_DM) && mem_rvalid;
    assign mem_req   = own_if || own_dm;
    assign mem_we    = own_dm && dm_we;
    assign mem_addr  = own_dm ? dm_addr : own_if ? if_addr : '0;
    assign mem_wdata = own_dm ? dm_wdata : '0;
    assign mem_be    = own_dm ? dm_be : '0;
    assign if_gnt    = own_if && mem_gnt;
    assign dm_gnt    = own_dm && mem_gnt;
    assign if_rvalid = state_q == RSP_IF && mem_rvalid && !drop_q && !if_flush;
    assign dm_rvalid = state_q == RSP_DM && mem_rvalid;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = dm_rvalid ? mem_rdata : '0;
    always_comb begin
        state_d = state_q;
        if (own_dm)
            state_d = mem_gnt ? RSP_DM : REQ_DM;
        else if (own_if)
            state_d = mem_gnt ? RSP_IF : REQ_IF;
        else if (rsp_done)
            state_d = IDLE;
    end
    // A killed fetch still completes on the bus; only its response is hidden.
    assign drop_d = (state_q == RSP_IF && mem_rvalid) ? 1'b0 :
                    drop_q | (if_flush && (state_q == REQ_IF || state_q == RSP_IF || (pick_if && mem_gnt)));
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q <= IDLE;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
        end
endmodule
